// File: rtl/convolution_procesor_bound_counter.sv
// Programmable index counter with a mode-selectable bound comparator.
// Advances the index by step_i on en_i and wraps to zero on a bound hit.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_n_i      synchronous active-low reset
//   start_i      latch limit_i, clear index, begin a run (IDLE only)
//   limit_i      bound, sampled when start is accepted
//   en_i         advance index by step_i this cycle (RUN only)
//   step_i       per-advance increment (0 holds the index)
//   count_o      current index
//   busy_o       high while running
//   done_o       one-cycle pulse after run completion
//   overshoot_o  sticky: the index went past the bound or out of range
//   runs_o       clean-run counter, present only with CONV_PROC_RUN_COUNTER_EN
//
// Optional macro: CONV_PROC_RUN_COUNTER_EN adds the saturating runs_o counter.
module convolution_procesor_bound_counter #(
    parameter int DATA_WIDTH = 13,
    parameter int STEP_WIDTH = 4,
    parameter int CMP_MODE   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] limit_i,
    input  logic                  en_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    output logic [DATA_WIDTH-1:0] count_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overshoot_o
`ifdef CONV_PROC_RUN_COUNTER_EN
    ,
    output logic [15:0]           runs_o
`endif
);

    // Unknown modes fall back to greater-or-equal.
    localparam int MODE = (CMP_MODE == 1) ? 1 :
                          (CMP_MODE == 2) ? 2 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] limit_q, limit_d;
    logic                  ovs_q, ovs_d;
    logic                  busy_q, done_q;

    // One extra bit so a step past the top of the range is visible.
    logic [DATA_WIDTH:0] next_w;
    logic [DATA_WIDTH:0] limit_w;
    logic                hit;
    logic                over;

    assign next_w  = {1'b0, count_q}
                   + {{(DATA_WIDTH + 1 - STEP_WIDTH){1'b0}}, step_i};
    assign limit_w = {1'b0, limit_q};

    always_comb begin
        hit = 1'b0;
        if (MODE == 1) begin
            hit = (next_w > limit_w);
        end else if (MODE == 2) begin
            hit = (next_w == limit_w);
        end else begin
            hit = (next_w >= limit_w);
        end
    end

    // In equality mode, stepping past the bound can never hit again.
    assign over = next_w[DATA_WIDTH]
                | ((MODE == 2) && (next_w > limit_w));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        ovs_d   = ovs_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    limit_d = limit_i;
                    count_d = '0;
                    ovs_d   = 1'b0;
                    // A zero bound is met immediately unless strictly greater.
                    if ((limit_i == '0) && (MODE != 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (en_i) begin
                    if (over) begin
                        count_d = '0;
                        ovs_d   = 1'b1;
                        state_d = DONE;
                    end else if (hit) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = next_w[DATA_WIDTH-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            ovs_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            ovs_q   <= ovs_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign count_o     = count_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign overshoot_o = ovs_q;

`ifdef CONV_PROC_RUN_COUNTER_EN
    logic [15:0] runs_q;

    // Count in the DONE cycle, where overshoot already reflects this run.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            runs_q <= '0;
        end else if ((state_q == DONE) && !ovs_q
                     && (runs_q != 16'hFFFF)) begin
            runs_q <= runs_q + 16'd1;
        end
    end

    assign runs_o = runs_q;
`endif

endmodule

// File: tb/tb_convolution_procesor_bound_counter.sv
// Bench for convolution_procesor_bound_counter.
// Four instances (modes 0/1/2, 4-bit width) share one stimulus stream.
module tb_convolution_procesor_bound_counter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [12:0] limit;
    logic        en;
    logic [3:0]  step;

    logic [12:0] c0, c1, c2;
    logic [3:0]  c3;
    logic        b0, b1, b2, b3;
    logic        d0, d1, d2, d3;
    logic        o0, o1, o2, o3;
`ifdef CONV_PROC_RUN_COUNTER_EN
    logic [15:0] r0, r1, r2, r3;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [12:0] count;
        logic        busy;
        logic        done;
        logic        ovs;
    } obs_t;

    typedef struct packed {
        logic [1:0] sel;
        obs_t       val;
    } exp_t;

    exp_t  sbq[$];
    string tagq[$];

    convolution_procesor_bound_counter #(
        .DATA_WIDTH(13), .STEP_WIDTH(4), .CMP_MODE(0)
    ) u0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .limit_i(limit), .en_i(en), .step_i(step),
        .count_o(c0), .busy_o(b0), .done_o(d0), .overshoot_o(o0)
`ifdef CONV_PROC_RUN_COUNTER_EN
        , .runs_o(r0)
`endif
    );

    convolution_procesor_bound_counter #(
        .DATA_WIDTH(13), .STEP_WIDTH(4), .CMP_MODE(1)
    ) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .limit_i(limit), .en_i(en), .step_i(step),
        .count_o(c1), .busy_o(b1), .done_o(d1), .overshoot_o(o1)
`ifdef CONV_PROC_RUN_COUNTER_EN
        , .runs_o(r1)
`endif
    );

    convolution_procesor_bound_counter #(
        .DATA_WIDTH(13), .STEP_WIDTH(4), .CMP_MODE(2)
    ) u2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .limit_i(limit), .en_i(en), .step_i(step),
        .count_o(c2), .busy_o(b2), .done_o(d2), .overshoot_o(o2)
`ifdef CONV_PROC_RUN_COUNTER_EN
        , .runs_o(r2)
`endif
    );

    convolution_procesor_bound_counter #(
        .DATA_WIDTH(4), .STEP_WIDTH(4), .CMP_MODE(2)
    ) u3 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .limit_i(limit[3:0]), .en_i(en), .step_i(step),
        .count_o(c3), .busy_o(b3), .done_o(d3), .overshoot_o(o3)
`ifdef CONV_PROC_RUN_COUNTER_EN
        , .runs_o(r3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t get_obs(input logic [1:0] s);
        obs_t r;
        case (s)
            2'd0:    r = '{c0, b0, d0, o0};
            2'd1:    r = '{c1, b1, d1, o1};
            2'd2:    r = '{c2, b2, d2, o2};
            default: r = '{{9'd0, c3}, b3, d3, o3};
        endcase
        return r;
    endfunction

    task automatic push(input string tag, input logic [1:0] s,
                        input logic [12:0] c, input logic b,
                        input logic d, input logic o);
        exp_t e;
        e.sel = s;
        e.val = '{c, b, d, o};
        sbq.push_back(e);
        tagq.push_back(tag);
    endtask

    task automatic compare_front();
        exp_t  e;
        string t;
        obs_t  ob;
        e  = sbq.pop_front();
        t  = tagq.pop_front();
        ob = get_obs(e.sel);
        checks++;
        assert (ob === e.val) else begin
            errors++;
            $error("FAIL %s observed cnt=%0d busy=%b done=%b ovs=%b expected cnt=%0d busy=%b done=%b ovs=%b",
                   t, ob.count, ob.busy, ob.done, ob.ovs,
                   e.val.count, e.val.busy, e.val.done, e.val.ovs);
        end
    endtask

    // Expectation for the state after the next rising edge.
    task automatic tick(input string tag, input logic [1:0] s,
                        input logic [12:0] c, input logic b,
                        input logic d, input logic o);
        push(tag, s, c, b, d, o);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    // Extra expectation on another instance for the same cycle.
    task automatic also(input string tag, input logic [1:0] s,
                        input logic [12:0] c, input logic b,
                        input logic d, input logic o);
        push(tag, s, c, b, d, o);
        compare_front();
    endtask

    task automatic do_reset(input logic [1:0] s);
        rst_n = 1'b0;
        start = 1'b0;
        en    = 1'b0;
        tick("reset", s, 13'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

`ifdef CONV_PROC_RUN_COUNTER_EN
    task automatic run_m2(input logic [12:0] l, input logic [3:0] s,
                          input logic ov);
        start = 1'b1;
        limit = l;
        tick("run_start", 2'd2, 13'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        en    = 1'b1;
        step  = s;
        tick("run_end", 2'd2, 13'd0, 1'b0, 1'b1, ov);
        en = 1'b0;
        tick("run_idle", 2'd2, 13'd0, 1'b0, 1'b0, ov);
    endtask

    task automatic check_runs(input string tag, input logic [15:0] exp);
        checks++;
        assert (r2 === exp) else begin
            errors++;
            $error("FAIL %s observed runs=%0d expected runs=%0d",
                   tag, r2, exp);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        limit = '0;
        en    = 1'b0;
        step  = '0;

        // Mode 0: limit 5, step 2
        do_reset(2'd0);
        start = 1'b1;
        limit = 13'd5;
        tick("m0_start", 2'd0, 13'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        en    = 1'b1;
        step  = 4'd2;
        tick("m0_c2", 2'd0, 13'd2, 1'b1, 1'b0, 1'b0);
        tick("m0_c4", 2'd0, 13'd4, 1'b1, 1'b0, 1'b0);
        tick("m0_hit", 2'd0, 13'd0, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        tick("m0_idle", 2'd0, 13'd0, 1'b0, 1'b0, 1'b0);

        // Mode 2: overshoot, sticky, cleared by start, exact hit
        do_reset(2'd2);
        start = 1'b1;
        limit = 13'd5;
        tick("m2_start", 2'd2, 13'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        en    = 1'b1;
        step  = 4'd2;
        tick("m2_c2", 2'd2, 13'd2, 1'b1, 1'b0, 1'b0);
        tick("m2_c4", 2'd2, 13'd4, 1'b1, 1'b0, 1'b0);
        tick("m2_ovs", 2'd2, 13'd0, 1'b0, 1'b1, 1'b1);
        en = 1'b0;
        tick("m2_sticky", 2'd2, 13'd0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        tick("m2_clr", 2'd2, 13'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        en    = 1'b1;
        step  = 4'd1;
        for (int i = 1; i <= 4; i++) begin
            tick("m2_walk", 2'd2, 13'(i), 1'b1, 1'b0, 1'b0);
        end
        tick("m2_exact", 2'd2, 13'd0, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        tick("m2_idle", 2'd2, 13'd0, 1'b0, 1'b0, 1'b0);

        // Zero limit: mode 0 skips RUN, mode 1 runs
        do_reset(2'd0);
        start = 1'b1;
        limit = 13'd0;
        tick("m0_lim0", 2'd0, 13'd0, 1'b0, 1'b1, 1'b0);
        also("m1_lim0", 2'd1, 13'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        en    = 1'b1;
        step  = 4'd1;
        tick("m0_lim0_end", 2'd0, 13'd0, 1'b0, 1'b0, 1'b0);
        also("m1_hit", 2'd1, 13'd0, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        tick("m1_idle", 2'd1, 13'd0, 1'b0, 1'b0, 1'b0);

        // 4-bit width: range overflow
        do_reset(2'd3);
        start = 1'b1;
        limit = 13'd15;
        tick("w4_start", 2'd3, 13'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        en    = 1'b1;
        step  = 4'd4;
        tick("w4_c4", 2'd3, 13'd4, 1'b1, 1'b0, 1'b0);
        tick("w4_c8", 2'd3, 13'd8, 1'b1, 1'b0, 1'b0);
        tick("w4_c12", 2'd3, 13'd12, 1'b1, 1'b0, 1'b0);
        tick("w4_ovs", 2'd3, 13'd0, 1'b0, 1'b1, 1'b1);
        en = 1'b0;
        tick("w4_sticky", 2'd3, 13'd0, 1'b0, 1'b0, 1'b1);

        // Mid-run: limit change, hold, ignored start, abort by reset
        do_reset(2'd0);
        start = 1'b1;
        limit = 13'd100;
        tick("mr_start", 2'd0, 13'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        limit = 13'd2;
        en    = 1'b1;
        step  = 4'd3;
        tick("mr_c3", 2'd0, 13'd3, 1'b1, 1'b0, 1'b0);
        tick("mr_c6", 2'd0, 13'd6, 1'b1, 1'b0, 1'b0);
        tick("mr_c9", 2'd0, 13'd9, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        tick("mr_hold", 2'd0, 13'd9, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        tick("mr_start_ign", 2'd0, 13'd9, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        en    = 1'b1;
        step  = 4'd0;
        tick("mr_step0", 2'd0, 13'd9, 1'b1, 1'b0, 1'b0);
        en    = 1'b0;
        rst_n = 1'b0;
        tick("mr_abort", 2'd0, 13'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick("mr_nodone", 2'd0, 13'd0, 1'b0, 1'b0, 1'b0);

`ifdef CONV_PROC_RUN_COUNTER_EN
        do_reset(2'd2);
        check_runs("runs_reset", 16'd0);
        run_m2(13'd2, 4'd2, 1'b0);
        run_m2(13'd4, 4'd4, 1'b0);
        run_m2(13'd1, 4'd2, 1'b1);
        check_runs("runs_two", 16'd2);
        force u2.runs_q = 16'hFFFF;
        #1;
        release u2.runs_q;
        run_m2(13'd2, 4'd2, 1'b0);
        check_runs("runs_sat", 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
